// File: rtl/unidad_de_control.sv
// unidad_de_control: registered opcode decoder for the MIPS-style datapath; UC_JUMP_EN adds the Jump output for j/jal
module unidad_de_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Opcode,
  input  logic       Flush,
  output logic       RegDst,
  output logic       ALUSrc,
  output logic       MemToReg,
  output logic       RegisterWrite,
  output logic       MemRead,
  output logic       MemToWrite,
  output logic       Branch,
  output logic [2:0] ALUOp,
  output logic       Illegal
`ifdef UC_JUMP_EN
  ,
  output logic       Jump
`endif
);
  // {RegDst, ALUSrc, MemToReg, RegisterWrite, MemRead, MemToWrite, Branch, ALUOp, Illegal}
  logic [10:0] dec, ctrl_d, ctrl_q;
  always_comb begin
    dec = 11'b0000000_000_1;
    case (Opcode)
      6'b000000: dec = 11'b1001000_010_0;
      6'b011100: dec = 11'b1001000_110_0;
      6'b100011: dec = 11'b0111100_000_0;
      6'b101011: dec = 11'b0100010_000_0;
      6'b000100: dec = 11'b0000001_001_0;
      6'b001000: dec = 11'b0101000_000_0;
      6'b001100: dec = 11'b0101000_011_0;
      6'b001101: dec = 11'b0101000_100_0;
      6'b001010: dec = 11'b0101000_101_0;
`ifdef UC_JUMP_EN
      6'b000010: dec = 11'b0000000_000_0;
      6'b000011: dec = 11'b0001000_000_0;
`endif
      default:   dec = 11'b0000000_000_1;
    endcase
    ctrl_d = Flush ? 11'd0 : dec;
  end
  always_ff @(posedge clk) ctrl_q <= rst ? 11'd0 : ctrl_d;
  assign {RegDst, ALUSrc, MemToReg, RegisterWrite, MemRead, MemToWrite, Branch, ALUOp, Illegal} = ctrl_q;
`ifdef UC_JUMP_EN
  logic jump_d, jump_q;
  assign jump_d = !Flush && (Opcode === 6'b000010 || Opcode === 6'b000011);
  always_ff @(posedge clk) jump_q <= rst ? 1'b0 : jump_d;
  assign Jump = jump_q;
`endif
endmodule

// File: tb/tb_unidad_de_control.sv
// tb_unidad_de_control: directed checks of unidad_de_control decode, flush, reset and latency, plus a 64-opcode sweep
module tb_unidad_de_control;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] Opcode = 6'b100011;
  logic       Flush = 1'b0;
  logic       RegDst, ALUSrc, MemToReg, RegisterWrite, MemRead, MemToWrite, Branch, Illegal;
  logic [2:0] ALUOp;
`ifdef UC_JUMP_EN
  logic       Jump;
`endif
  logic [10:0] obs;
  int n_assert = 0;
  int n_fail = 0;

  localparam logic [10:0] E_Z    = 11'b0000000_000_0;
  localparam logic [10:0] E_NOP  = 11'b0000000_000_1;
  localparam logic [10:0] E_R    = 11'b1001000_010_0;
  localparam logic [10:0] E_MUL  = 11'b1001000_110_0;
  localparam logic [10:0] E_LW   = 11'b0111100_000_0;
  localparam logic [10:0] E_SW   = 11'b0100010_000_0;
  localparam logic [10:0] E_BEQ  = 11'b0000001_001_0;
  localparam logic [10:0] E_ADDI = 11'b0101000_000_0;
  localparam logic [10:0] E_ANDI = 11'b0101000_011_0;
  localparam logic [10:0] E_ORI  = 11'b0101000_100_0;
  localparam logic [10:0] E_SLTI = 11'b0101000_101_0;

  unidad_de_control dut (
    .clk(clk), .rst(rst), .Opcode(Opcode), .Flush(Flush),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .MemToReg(MemToReg), .RegisterWrite(RegisterWrite),
    .MemRead(MemRead), .MemToWrite(MemToWrite), .Branch(Branch), .ALUOp(ALUOp), .Illegal(Illegal)
`ifdef UC_JUMP_EN
    , .Jump(Jump)
`endif
  );

  always #5 clk = ~clk;
  assign obs = {RegDst, ALUSrc, MemToReg, RegisterWrite, MemRead, MemToWrite, Branch, ALUOp, Illegal};

  task automatic apply(input logic [5:0] op, input logic fl, input logic r);
    @(negedge clk);
    Opcode = op;
    Flush = fl;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [10:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic got, input logic exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic legal(input logic [5:0] op);
`ifdef UC_JUMP_EN
    if (op == 6'b000010 || op == 6'b000011) return 1'b1;
`endif
    return op inside {6'b000000, 6'b011100, 6'b100011, 6'b101011, 6'b000100,
                      6'b001000, 6'b001100, 6'b001101, 6'b001010};
  endfunction

  initial begin
    @(posedge clk); #1;
    chk("reset_c1", E_Z);
    @(posedge clk); #1;
    chk("reset_c2", E_Z);
    apply(6'b100011, 1'b0, 1'b0);
    chk("lw_after_reset", E_LW);
    for (int i = 0; i < 10; i++) begin apply(6'b000000, 1'b0, 1'b0); chk("rtype", E_R); end
    for (int i = 0; i < 10; i++) begin apply(6'b011100, 1'b0, 1'b0); chk("special2", E_MUL); end
    for (int i = 0; i < 10; i++) begin apply(6'b000001, 1'b0, 1'b0); chk("regimm", E_NOP); end
    apply(6'b100011, 1'b0, 1'b0); chk("lw", E_LW);
    apply(6'b101011, 1'b0, 1'b0); chk("sw", E_SW);
    apply(6'b000100, 1'b0, 1'b0); chk("beq", E_BEQ);
    apply(6'b001000, 1'b0, 1'b0); chk("addi", E_ADDI);
    apply(6'b001100, 1'b0, 1'b0); chk("andi", E_ANDI);
    apply(6'b001101, 1'b0, 1'b0); chk("ori", E_ORI);
    apply(6'b001010, 1'b0, 1'b0); chk("slti", E_SLTI);
    apply(6'b000000, 1'b1, 1'b0); chk("flush_rtype", E_Z);
    apply(6'b000001, 1'b1, 1'b0); chk("flush_illegal", E_Z);
    apply(6'b100011, 1'b0, 1'b0); chk("lw_before_rst_flush", E_LW);
    apply(6'b100011, 1'b1, 1'b1); chk("rst_and_flush", E_Z);
    apply(6'b101011, 1'b0, 1'b1); chk("rst_over_opcode", E_Z);
    apply(6'b000000, 1'b0, 1'b0); chk("lat_rtype", E_R);
    apply(6'b100011, 1'b0, 1'b0); chk("lat_lw", E_LW);
    @(negedge clk);
    Opcode = 6'b101011;
    #1;
    chk("no_comb_path", E_LW);
    @(posedge clk); #1;
    chk("lat_sw", E_SW);
    for (int op = 0; op < 64; op++) begin
      apply(6'(op), 1'b0, 1'b0);
      chk_bit($sformatf("inv_rd_wr_%0d", op), MemRead && MemToWrite, 1'b0);
      chk_bit($sformatf("inv_wr_rw_%0d", op), MemToWrite && RegisterWrite, 1'b0);
      chk_bit($sformatf("inv_br_%0d", op), Branch && (RegisterWrite || MemToWrite), 1'b0);
      chk_bit($sformatf("aluop_res_%0d", op), ALUOp == 3'b111, 1'b0);
      chk_bit($sformatf("illegal_%0d", op), Illegal, !legal(6'(op)));
      if (!legal(6'(op))) chk($sformatf("nop_%0d", op), E_NOP);
`ifdef UC_JUMP_EN
      chk_bit($sformatf("jump_%0d", op), Jump, op == 2 || op == 3);
      if (op == 2) chk("j", E_Z);
      if (op == 3) chk("jal", 11'b0001000_000_0);
`endif
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/unidad_de_control.md
Name: unidad_de_control

Overview:
- Main control unit for the team's single-issue MIPS-style datapath.
- Decodes the 6-bit instruction opcode into datapath control strobes and a 3-bit ALU operation class for the ALU control block.
- All outputs are registered and feed the execute/memory/writeback control path one cycle after the opcode is presented.
- A flush input inserts a bubble; an illegal-opcode flag marks undecoded instructions.

Parameters:
- None. All widths are fixed: Opcode 6 bits, ALUOp 3 bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- Opcode  input  6  instruction bits [31:26]
- Flush  input  1  forces NOP outputs at the next edge
- RegDst  output  1  1 = write register is rd; 0 = rt
- ALUSrc  output  1  1 = ALU operand B is the sign-extended immediate; 0 = register rt
- MemToReg  output  1  1 = writeback data comes from memory; 0 = from the ALU
- RegisterWrite  output  1  register file write enable
- MemRead  output  1  data memory read enable
- MemToWrite  output  1  data memory write enable
- Branch  output  1  conditional branch (beq) instruction
- ALUOp  output  3  ALU operation class
- Illegal  output  1  opcode not in the decode table

Behaviour:
- Reset: on a rising clk with rst=1, every output goes to 0, including ALUOp=000 and Illegal=0. rst has priority over Flush and Opcode.
- Latency: one cycle. Outputs at edge N+1 reflect the Opcode sampled at edge N. There is no combinational path from input to output.
- Flush=1 (rst=0): all outputs go to 0 at the next edge, including Illegal, regardless of Opcode.
- Decode table. Listed signals are 1, all others are 0:
  - 000000 R-type: RegDst, RegisterWrite; ALUOp=010.
  - 011100 SPECIAL2 (mul class): RegDst, RegisterWrite; ALUOp=110.
  - 100011 lw: ALUSrc, MemToReg, RegisterWrite, MemRead; ALUOp=000.
  - 101011 sw: ALUSrc, MemToWrite; ALUOp=000.
  - 000100 beq: Branch; ALUOp=001.
  - 001000 addi: ALUSrc, RegisterWrite; ALUOp=000.
  - 001100 andi: ALUSrc, RegisterWrite; ALUOp=011.
  - 001101 ori: ALUSrc, RegisterWrite; ALUOp=100.
  - 001010 slti: ALUSrc, RegisterWrite; ALUOp=101.
  - ALUOp=111 is reserved and never produced.
- Any other opcode, including 000001 (REGIMM), decodes as a NOP: all strobes 0, ALUOp=000, Illegal=1.
- Invariants, for every opcode and every cycle:
  - MemRead and MemToWrite are never both 1.
  - MemToWrite=1 implies RegisterWrite=0.
  - Branch=1 implies RegisterWrite=0 and MemToWrite=0.
- An Opcode that changes every cycle is decoded independently each cycle. There is no internal state beyond the output registers.
- An opcode with X or Z bits is treated as illegal; the outputs must not propagate X.

Optional Feature:
- Macro: UC_JUMP_EN.
- Defined:
  - Adds output port Jump (1 bit, reset 0, cleared by Flush).
  - Opcode 000010 (j) decodes to Jump=1, all other strobes 0, ALUOp=000, Illegal=0.
  - Opcode 000011 (jal) decodes to Jump=1, RegisterWrite=1, ALUOp=000, Illegal=0; register $31 is selected by the datapath.
- Undefined:
  - No Jump port.
  - 000010 and 000011 are illegal: NOP outputs with Illegal=1.

Test Plan:
- Reset: rst=1 for 2 cycles with Opcode=100011 -> every output 0. Release rst -> outputs show lw decoding one edge later.
- Sequence Opcode 000000, then 011100, then 000001, each held 100 ns:
  - 000000 -> RegDst=1, RegisterWrite=1, ALUOp=010, Illegal=0.
  - 011100 -> RegDst=1, RegisterWrite=1, ALUOp=110.
  - 000001 -> all strobes 0, ALUOp=000, Illegal=1.
- Memory ops:
  - 100011 -> ALUSrc=MemToReg=RegisterWrite=MemRead=1, ALUOp=000.
  - 101011 -> ALUSrc=MemToWrite=1, RegisterWrite=0.
- Branch and immediates:
  - 000100 -> Branch=1, ALUOp=001.
  - 001000 / 001100 / 001101 / 001010 -> ALUSrc=1, RegisterWrite=1, ALUOp=000 / 011 / 100 / 101 respectively.
- Flush and priority:
  - Opcode=000000 with Flush=1 -> all 0 next edge.
  - rst=1 and Flush=1 together -> all 0.
  - Check the one-cycle latency by changing Opcode every edge: 000000, 100011, 101011.
- Exhaustive sweep of all 64 opcodes, with and without UC_JUMP_EN:
  - Invariants hold on every opcode.
  - Illegal=1 exactly for opcodes absent from the decode table.
  - 000010 gives Jump=1 only when UC_JUMP_EN is defined.
